// File: rtl/gpr_wb_pkg.sv
// Shared types and constants for the dual-issue GPR writeback arbiter.
package gpr_wb_pkg;
  localparam int WB_XLEN = 32;
  localparam int RD_W    = 5;
  localparam int NREQ    = 4;
  localparam int NWPORT  = 2;

  localparam int SLOT_MEM_U  = 0;
  localparam int SLOT_MEM_L  = 1;
  localparam int SLOT_EXEC_U = 2;
  localparam int SLOT_EXEC_L = 3;

  typedef struct packed {
    logic                valid;
    logic [RD_W-1:0]     rd;
    logic [WB_XLEN-1:0]  data;
  } wb_req_t;
endpackage

// File: rtl/wb_compact_queue.sv
// Age-ordered compacting writeback queue: squash-by-rd, push up to four, pop up to two.
module wb_compact_queue
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  wb_req_t [NREQ-1:0]     push,
  input  logic [NWPORT*RD_W-1:0] query_addr,
  output wb_req_t [NWPORT-1:0]   pop,
  output logic [NWPORT-1:0]      query_match,
  output logic [CW-1:0]          count,
  output logic [CW-1:0]          count_next
);
  localparam int NCAND = DEPTH + NREQ;
  localparam int NKEEP = DEPTH + NWPORT;
  localparam int NW    = $clog2(NCAND + 1);

  wb_req_t [DEPTH-1:0] q_reg;
  wb_req_t [NCAND-1:0] cand;
  wb_req_t [NKEEP-1:0] keep;
  logic [NW-1:0]       n;
  logic [CW-1:0]       count_reg;

  // Queue entries first (oldest), then this edge's survivors; a younger push kills same-rd entries.
  always_comb begin
    cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = q_reg[i];
      for (int j = 0; j < NREQ; j++)
        if (push[j].valid && push[j].rd == q_reg[i].rd) cand[i].valid = 1'b0;
    end
    for (int j = 0; j < NREQ; j++) cand[DEPTH+j] = push[j];
  end

  always_comb begin
    keep = '0;
    n    = '0;
    for (int k = 0; k < NCAND; k++) begin
      if (cand[k].valid) begin
        if (n < NW'(NKEEP)) keep[n] = cand[k];
        n = n + 1'b1;
      end
    end
  end

  assign pop        = keep[NWPORT-1:0];
  assign count_next = (n > NW'(NWPORT)) ? CW'(n - NW'(NWPORT)) : '0;
  assign count      = count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg     <= '0;
      count_reg <= '0;
    end else begin
      q_reg     <= keep[NKEEP-1:NWPORT];
      count_reg <= count_next;
    end
  end

  for (genvar gi = 0; gi < NWPORT; gi++) begin : g_query
    logic hit;
    always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
        if (q_reg[i].valid && q_reg[i].rd == query_addr[gi*RD_W +: RD_W]) hit = 1'b1;
    end
    assign query_match[gi] = hit;
  end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: accepts four requests per cycle, squashes WAW-dead writes,
// drains two per cycle onto the register-file write ports and answers hazard queries.
module gpr_wb_arbiter
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = WB_XLEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*RD_W-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0]   req_data,
  output logic [NWPORT-1:0]      wr_en,
  output logic [NWPORT*RD_W-1:0] wr_addr,
  output logic [NWPORT*XLEN-1:0] wr_data,
  output logic                   stall,
  input  logic [NWPORT*RD_W-1:0] query_addr,
  output logic [NWPORT-1:0]      query_pend,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t [NREQ-1:0]     push;
  wb_req_t [NWPORT-1:0]   pop;
  logic [NWPORT-1:0]      q_match;
  logic [CW-1:0]          count_next;
  logic [NWPORT-1:0]      wr_en_reg;
  logic [NWPORT*RD_W-1:0] wr_addr_reg;
  logic [NWPORT*XLEN-1:0] wr_data_reg;
  logic                   stall_reg;

  // A slot survives unless a younger (higher-index) slot targets the same rd this cycle.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    logic [RD_W-1:0] rd;
    logic            younger_hit;
    assign rd = req_rd[gi*RD_W +: RD_W];
    always_comb begin
      younger_hit = 1'b0;
      for (int j = gi + 1; j < NREQ; j++)
        if (req_valid[j] && req_rd[j*RD_W +: RD_W] == rd) younger_hit = 1'b1;
    end
    assign push[gi] = {~stall_reg & req_valid[gi] & (rd != '0) & ~younger_hit,
                       rd, req_data[gi*XLEN +: XLEN]};
  end

  wb_compact_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .query_addr  (query_addr),
    .pop         (pop),
    .query_match (q_match),
    .count       (occupancy),
    .count_next  (count_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_reg   <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      stall_reg   <= 1'b0;
    end else begin
      for (int p = 0; p < NWPORT; p++) begin
        wr_en_reg[p]                  <= pop[p].valid;
        wr_addr_reg[p*RD_W +: RD_W]   <= pop[p].rd;
        wr_data_reg[p*XLEN +: XLEN]   <= pop[p].data;
      end
      // Stall keeps room for a full four-request cycle.
      stall_reg <= count_next > CW'(DEPTH - 4);
    end
  end

  for (genvar gi = 0; gi < NWPORT; gi++) begin : g_pend
    logic [RD_W-1:0] qa;
    logic            port_hit;
    assign qa = query_addr[gi*RD_W +: RD_W];
    always_comb begin
      port_hit = 1'b0;
      for (int p = 0; p < NWPORT; p++)
        if (wr_en_reg[p] && wr_addr_reg[p*RD_W +: RD_W] == qa) port_hit = 1'b1;
    end
    assign query_pend[gi] = (qa != '0) & (q_match[gi] | port_hit);
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign stall   = stall_reg;
endmodule
